// File: rtl/pool_kxk_stream_pkg.sv
// Shared constants and helpers for the K x K streaming pooling stage.
package pool_kxk_stream_pkg;
  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  // Counter/address width: ceil(log2(n)), never narrower than one bit.
  function automatic int pool_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/pool_row_buf.sv
// One accumulator per output column of the current window row; combinational read, synchronous write.
module pool_row_buf #(
  parameter int DEPTH = 6,
  parameter int ACC_W = 18,
  parameter int AW    = 3
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_addr,
  input  logic signed [ACC_W-1:0] i_wdata,
  output logic signed [ACC_W-1:0] o_rdata
);
  logic signed [ACC_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/pool_kxk_stream.sv
// Handshaked K x K non-overlapping max/average pooling over a raster-ordered multi-channel stream.
module pool_kxk_stream
  import pool_kxk_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_WIDTH   = 12,
  parameter int IN_HEIGHT  = 12,
  parameter int NUM_CH     = 6,
  parameter int POOL_K     = 2,
  parameter int K_LOG2     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done,
  output logic                  err_frame
);
  localparam int OUT_W = IN_WIDTH / POOL_K;
  localparam int OUT_H = IN_HEIGHT / POOL_K;
  localparam int ACC_W = DATA_WIDTH + 2 * K_LOG2;
  localparam int CW    = pool_clog2(IN_WIDTH);
  localparam int RW    = pool_clog2(IN_HEIGHT);
  localparam int HW    = pool_clog2(NUM_CH);
  localparam int AW    = pool_clog2(OUT_W);

  // Arithmetic shift floors toward -inf, matching the divide-by-K^2 definition.
  function automatic logic signed [DATA_WIDTH-1:0] avg_floor(input logic signed [ACC_W-1:0] sum);
    return DATA_WIDTH'(sum >>> (2 * K_LOG2));
  endfunction

  function automatic logic signed [ACC_W-1:0] smax(input logic signed [ACC_W-1:0] a,
                                                   input logic signed [ACC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic [HW-1:0]                r_ch;
  logic                         r_mode_q;
  logic                         r_vld_p1;
  logic                         r_lastwin_p1;
  logic                         r_err_p1;
  logic signed [DATA_WIDTH-1:0] r_data_p1;

  logic                         w_in_hs, w_out_hs;
  logic                         w_last_col, w_last_row, w_last_ch, w_final_pos, w_frame_start;
  logic [CW-1:0]                w_oc_full;
  logic [RW-1:0]                w_orow;
  logic [K_LOG2-1:0]            w_kx, w_ky;
  logic                         w_in_win, w_first_px, w_final_px, w_buf_we, w_load, w_lastwin;
  logic signed [ACC_W-1:0]      w_px_ext, w_buf_rd, w_acc_max, w_acc_sum, w_buf_wd;
  logic signed [DATA_WIDTH-1:0] w_result;

  assign in_ready      = !r_vld_p1 || out_ready;
  assign w_in_hs       = in_valid && in_ready;
  assign w_out_hs      = r_vld_p1 && out_ready;

  assign w_last_col    = (r_col == CW'(IN_WIDTH - 1));
  assign w_last_row    = (r_row == RW'(IN_HEIGHT - 1));
  assign w_last_ch     = (r_ch == HW'(NUM_CH - 1));
  assign w_final_pos   = w_last_col && w_last_row && w_last_ch;
  assign w_frame_start = (r_col == '0) && (r_row == '0) && (r_ch == '0);

  assign w_kx          = r_col[K_LOG2-1:0];
  assign w_ky          = r_row[K_LOG2-1:0];
  assign w_oc_full     = r_col >> K_LOG2;
  assign w_orow        = r_row >> K_LOG2;
  // Trailing columns/rows that cannot fill a whole window are accepted but ignored.
  assign w_in_win      = (w_oc_full < CW'(OUT_W)) && (w_orow < RW'(OUT_H));
  assign w_first_px    = (w_kx == '0) && (w_ky == '0);
  assign w_final_px    = (w_kx == '1) && (w_ky == '1);
  assign w_lastwin     = (w_oc_full == CW'(OUT_W - 1)) && (w_orow == RW'(OUT_H - 1)) && w_last_ch;

  assign w_px_ext  = {{(ACC_W - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign w_acc_max = smax(w_buf_rd, w_px_ext);
  assign w_acc_sum = w_buf_rd + w_px_ext;
  assign w_buf_wd  = w_first_px ? w_px_ext :
                     (r_mode_q == POOL_MODE_AVG) ? w_acc_sum : w_acc_max;
  assign w_buf_we  = w_in_hs && w_in_win && !w_final_px;
  assign w_load    = w_in_hs && w_in_win && w_final_px;
  assign w_result  = (r_mode_q == POOL_MODE_MAX) ? w_acc_max[DATA_WIDTH-1:0] : avg_floor(w_acc_sum);

  pool_row_buf #(
    .DEPTH (OUT_W),
    .ACC_W (ACC_W),
    .AW    (AW)
  ) u_row_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_addr  (w_oc_full[AW-1:0]),
    .i_wdata (w_buf_wd),
    .o_rdata (w_buf_rd)
  );

  // Any in_last, legal or not, realigns the position counters to a fresh frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col    <= '0;
      r_row    <= '0;
      r_ch     <= '0;
      r_mode_q <= POOL_MODE_MAX;
      r_err_p1 <= 1'b0;
    end else begin
      r_err_p1 <= w_in_hs && (in_last != w_final_pos);
      if (w_in_hs && w_frame_start) r_mode_q <= mode;
      if (w_in_hs) begin
        if (in_last || w_final_pos) begin
          r_col <= '0;
          r_row <= '0;
          r_ch  <= '0;
        end else if (!w_last_col) begin
          r_col <= r_col + 1'b1;
        end else begin
          r_col <= '0;
          if (!w_last_row) begin
            r_row <= r_row + 1'b1;
          end else begin
            r_row <= '0;
            r_ch  <= r_ch + 1'b1;
          end
        end
      end
    end
  end

  // ---- stage p1: output register, loads while the previous result drains ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1     <= 1'b0;
      r_data_p1    <= '0;
      r_lastwin_p1 <= 1'b0;
    end else if (w_load) begin
      r_vld_p1     <= 1'b1;
      r_data_p1    <= w_result;
      r_lastwin_p1 <= w_lastwin;
    end else if (w_out_hs) begin
      r_vld_p1     <= 1'b0;
    end
  end

  assign out_valid  = r_vld_p1;
  assign out_data   = r_data_p1;
  assign frame_done = w_out_hs && r_lastwin_p1;
  assign err_frame  = r_err_p1;
endmodule

// File: tb/tb_pool_kxk_stream.sv
// Randomised and directed checks of pool_kxk_stream against a window-level reference model.
module tb_pool_kxk_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mode, in_valid, in_last, sel;
  logic        man_rdy, bp_en;
  logic        bp_rdy = 1'b1;
  logic [15:0] in_data;
  logic        out_ready;
  logic        vld_a, vld_b, rdy_a, rdy_b, ov_a, ov_b, done_a, done_b, err_a, err_b;
  logic [15:0] dout_a, dout_b;

  assign out_ready = bp_en ? bp_rdy : man_rdy;
  assign vld_a     = in_valid && !sel;
  assign vld_b     = in_valid && sel;

  pool_kxk_stream #(.DATA_WIDTH(16), .IN_WIDTH(4), .IN_HEIGHT(4), .NUM_CH(1), .POOL_K(2), .K_LOG2(1)) u_dut_a (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(vld_a), .in_ready(rdy_a), .in_data(in_data),
    .in_last(in_last), .out_valid(ov_a), .out_ready(out_ready), .out_data(dout_a),
    .frame_done(done_a), .err_frame(err_a));

  pool_kxk_stream #(.DATA_WIDTH(16), .IN_WIDTH(5), .IN_HEIGHT(5), .NUM_CH(2), .POOL_K(2), .K_LOG2(1)) u_dut_b (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(vld_b), .in_ready(rdy_b), .in_data(in_data),
    .in_last(in_last), .out_valid(ov_b), .out_ready(out_ready), .out_data(dout_b),
    .frame_done(done_b), .err_frame(err_b));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    #2;
    bp_rdy = ($urandom_range(0, 3) != 0);
  end

  int qd_a[$], qf_a[$], qd_b[$], qf_b[$];
  int n_err_a = 0, n_err_b = 0;
  int rd_a = 0, rd_b = 0, eb_a = 0, eb_b = 0;
  logic        p_hold = 1'b0;
  logic [15:0] p_data = '0;

  // Output monitor: records handshakes and checks the hold/ready rules on the 4x4 instance
  always @(negedge clk) begin
    if (ov_a && out_ready) begin qd_a.push_back(int'($signed(dout_a))); qf_a.push_back(int'(done_a)); end
    if (ov_b && out_ready) begin qd_b.push_back(int'($signed(dout_b))); qf_b.push_back(int'(done_b)); end
    if (err_a) n_err_a++;
    if (err_b) n_err_b++;
    if (!reset) begin
      chk("in_ready_rule", rdy_a, !ov_a || out_ready);
      if (p_hold) begin
        chk("stall_valid", ov_a, 1);
        chk("stall_data", $signed(dout_a), $signed(p_data));
      end
    end
    p_hold = ov_a && !out_ready;
    p_data = dout_a;
  end

  logic signed [15:0] px[$];
  int qe_d[$], qe_f[$];

  task automatic send(input logic s, input logic [15:0] d, input logic last);
    int t;
    sel = s; in_data = d; in_last = last; in_valid = 1'b1;
    t = 0;
    while (!(s ? rdy_b : rdy_a) && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) chk("in_ready_wait", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drive(input logic s, input logic m, input int last_at, input int tog_at, input int maxgap);
    mode = m;
    for (int i = 0; i < px.size(); i++) begin
      if (i == tog_at) mode = ~m;
      send(s, px[i], i == last_at);
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  // Reference: every complete KxK window, in order of its bottom-right pixel, among the first n pixels.
  task automatic model(input int w, input int h, input int nch, input logic m, input int n);
    int ow, oh, base, a0, a1, a2, a3, r;
    ow = w / 2; oh = h / 2;
    for (int c = 0; c < nch; c++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          base = c * w * h + 2 * oy * w + 2 * ox;
          if (base + w + 1 < n) begin
            a0 = px[base]; a1 = px[base + 1]; a2 = px[base + w]; a3 = px[base + w + 1];
            if (m) r = (a0 + a1 + a2 + a3) >>> 2;
            else begin
              r = a0;
              if (a1 > r) r = a1;
              if (a2 > r) r = a2;
              if (a3 > r) r = a3;
            end
            qe_d.push_back(r);
            qe_f.push_back((c == nch - 1 && oy == oh - 1 && ox == ow - 1) ? 1 : 0);
          end
        end
  endtask

  task automatic exp4(input int d0, input int d1, input int d2, input int d3, input int lastflag);
    qe_d.push_back(d0); qe_d.push_back(d1); qe_d.push_back(d2); qe_d.push_back(d3);
    qe_f.push_back(0); qe_f.push_back(0); qe_f.push_back(0); qe_f.push_back(lastflag);
  endtask

  task automatic load_f();
    int f[16] = '{1, 5, 2, 0, 3, -7, 8, 4, 0, 0, -1, -2, 9, 1, -3, -4};
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back(16'(f[i]));
  endtask

  task automatic check_out(input logic s, input string tag, input int err_exp);
    int t, got, base, nerr;
    t = 0;
    while (((s ? qd_b.size() : qd_a.size()) - (s ? rd_b : rd_a)) < qe_d.size() && t < 3000) begin
      @(negedge clk); t++;
    end
    repeat (6) @(negedge clk);
    base = s ? rd_b : rd_a;
    got  = (s ? qd_b.size() : qd_a.size()) - base;
    chk({tag, "_count"}, got, qe_d.size());
    for (int i = 0; i < got && i < qe_d.size(); i++) begin
      chk({tag, "_data"}, s ? qd_b[base + i] : qd_a[base + i], qe_d[i]);
      chk({tag, "_done"}, s ? qf_b[base + i] : qf_a[base + i], qe_f[i]);
    end
    nerr = s ? (n_err_b - eb_b) : (n_err_a - eb_a);
    chk({tag, "_err"}, nerr, err_exp);
    if (s) begin rd_b = qd_b.size(); eb_b = n_err_b; end
    else   begin rd_a = qd_a.size(); eb_a = n_err_a; end
    qe_d.delete(); qe_f.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, cut;
    reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    sel = 1'b0; man_rdy = 1'b1; bp_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_data", dout_a, 0);
    chk("rst_frame_done", done_a, 0);
    chk("rst_err_frame", err_a, 0);
    chk("rst_in_ready", rdy_a, 1);
    reset = 1'b0;
    @(negedge clk);

    load_f(); exp4(5, 8, 9, -1, 1); drive(0, 0, 15, -1, 0); check_out(0, "max4x4", 0);
    load_f(); exp4(0, 3, 2, -3, 1); drive(0, 1, 15, -1, 1); check_out(0, "avg4x4", 0);

    @(posedge clk); #2 man_rdy = 1'b0;
    @(negedge clk);
    load_f(); exp4(5, 8, 9, -1, 1);
    fork
      drive(0, 0, 15, -1, 0);
      begin
        int t;
        t = 0;
        while (!ov_a && t < 200) begin @(negedge clk); t++; end
        chk("hold_seen", ov_a, 1);
        repeat (4) begin
          @(negedge clk);
          chk("hold_valid", ov_a, 1);
          chk("hold_data", $signed(dout_a), 5);
          chk("hold_in_ready", rdy_a, 0);
        end
        @(posedge clk); #2 man_rdy = 1'b1;
      end
    join
    check_out(0, "backpressure", 0);

    load_f(); while (px.size() > 11) void'(px.pop_back());
    qe_d.push_back(5); qe_f.push_back(0); qe_d.push_back(8); qe_f.push_back(0);
    drive(0, 0, 10, -1, 0); check_out(0, "early_last", 1);
    load_f(); exp4(5, 8, 9, -1, 1); drive(0, 0, 15, -1, 0); check_out(0, "after_err", 0);

    load_f(); while (px.size() > 6) void'(px.pop_back());
    qe_d.push_back(5); qe_f.push_back(0);
    drive(0, 0, -1, -1, 0); check_out(0, "partial", 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_valid", ov_a, 0);
    reset = 1'b0;
    @(negedge clk);
    load_f(); exp4(5, 8, 9, -1, 1); drive(0, 0, 15, -1, 0); check_out(0, "after_reset", 0);

    load_f(); exp4(0, 3, 2, -3, 1); drive(0, 1, 15, 3, 0); check_out(0, "mode_toggle", 0);

    px.delete();
    for (int c = 0; c < 2; c++) for (int i = 0; i < 25; i++) px.push_back(16'(i));
    exp4(6, 8, 16, 18, 0); exp4(6, 8, 16, 18, 1);
    drive(1, 0, 49, -1, 0); check_out(1, "ramp5x5", 0);

    @(posedge clk); #2 bp_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      px.delete();
      for (int i = 0; i < 16; i++) px.push_back(16'($urandom));
      m = $urandom_range(0, 1);
      model(4, 4, 1, m[0], 16);
      drive(0, m[0], 15, 5 + k, 2);
      check_out(0, "rand_a", 0);
    end

    for (int k = 0; k < 4; k++) begin
      px.delete();
      for (int i = 0; i < 50; i++) px.push_back(16'($urandom));
      m = $urandom_range(0, 1);
      if (k == 1) begin
        model(5, 5, 2, m[0], 50);
        drive(1, m[0], -1, -1, 2);
        check_out(1, "rand_b_nolast", 1);
      end else if (k == 2) begin
        cut = $urandom_range(8, 45);
        while (px.size() > cut + 1) void'(px.pop_back());
        model(5, 5, 2, m[0], cut + 1);
        drive(1, m[0], cut, -1, 2);
        check_out(1, "rand_b_early", 1);
      end else begin
        model(5, 5, 2, m[0], 50);
        drive(1, m[0], 49, 20, 2);
        check_out(1, "rand_b", 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
